// File: rtl/display_frame_builder_pkg.sv
// Shared types and constants for the display frame builder: state encoding,
// segment bit positions and frame geometry.
package display_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXPAND  = 2'd1,
      ST_PENDING = 2'd2
   } state_e;

   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   localparam logic [7:0] SEG_OFF = 8'h00;

   localparam int NUM_DIGITS = 9;
   localparam int FRAME_W    = 72;

   // Assemble one digit byte from the a..g field and the decimal point.
   function automatic logic [7:0] seg_byte(input logic [6:0] segs, input logic dp);
      logic [7:0] b;
      b             = SEG_OFF;
      b[SEG_G:SEG_A] = segs;
      b[SEG_DP]     = dp;
      return b;
   endfunction

endpackage

// File: rtl/display_frame_builder_hex_to_7seg.sv
// Combinational hex nibble to a..g segment decoder (bit 0 = a, bit 6 = g).
module hex_to_7seg
   import display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   // Glyph table; lowercase b and d keep them distinct from 8 and 0.
   always_comb begin
      seg = 7'h00;
      case (nibble)
         4'h0:    seg = 7'h3F;
         4'h1:    seg = 7'h06;
         4'h2:    seg = 7'h5B;
         4'h3:    seg = 7'h4F;
         4'h4:    seg = 7'h66;
         4'h5:    seg = 7'h6D;
         4'h6:    seg = 7'h7D;
         4'h7:    seg = 7'h07;
         4'h8:    seg = 7'h7F;
         4'h9:    seg = 7'h6F;
         4'hA:    seg = 7'h77;
         4'hB:    seg = 7'h7C;
         4'hC:    seg = 7'h39;
         4'hD:    seg = 7'h5E;
         4'hE:    seg = 7'h79;
         4'hF:    seg = 7'h71;
         default: seg = 7'h00;
      endcase
   end

endmodule

// File: rtl/display_frame_builder.sv
// Builds a nine-digit segment frame in a shadow register, one hex digit per
// cycle, and commits it to display_bits only on the shifter's frame boundary.
module display_frame_builder
   import display_pkg::*;
#(
   parameter bit SEG_ACTIVE_LOW = 1'b0,
   parameter bit BLANK_LEADING  = 1'b1
)
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                val_valid,
   output logic                val_ready,
   input  logic [31:0]         val_data,
   input  logic [7:0]          val_dp,
   input  logic                raw_we,
   input  logic [7:0]          raw_seg,
   input  logic                frame_tick,
   output logic [FRAME_W-1:0]  display_bits,
   output logic                commit_pending
);

   localparam logic [FRAME_W-1:0] INV_MASK   = {FRAME_W{SEG_ACTIVE_LOW}};
   localparam logic [FRAME_W-1:0] SHADOW_OFF = {NUM_DIGITS{SEG_OFF}};
   localparam logic [FRAME_W-1:0] FRAME_OFF  = SHADOW_OFF ^ INV_MASK;

   state_e               state_q, state_d;
   logic                 val_ready_q, val_ready_d;
   logic                 pending_q, pending_d;
   logic [31:0]          data_q, data_d;
   logic [7:0]           dp_q, dp_d;
   logic [2:0]           idx_q, idx_d;
   logic                 seen_nz_q, seen_nz_d;
   logic [FRAME_W-1:0]   shadow_q, shadow_d;
   logic [FRAME_W-1:0]   display_q, display_d;

   logic [3:0]           nib_s;
   logic [6:0]           seg_s;
   logic                 blank_s;
   logic [7:0]           digit_s;

   assign nib_s   = data_q[{idx_q, 2'b00} +: 4];
   assign blank_s = BLANK_LEADING && (nib_s == 4'h0) && !seen_nz_q && (idx_q != 3'd0);
   assign digit_s = seg_byte(blank_s ? 7'h00 : seg_s, dp_q[idx_q]);

   hex_to_7seg u_dec (
      .nibble (nib_s),
      .seg    (seg_s)
   );

   // Next-state logic: value expansion, raw digit writes and frame commit.
   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      dp_d      = dp_q;
      idx_d     = idx_q;
      seen_nz_d = seen_nz_q;
      shadow_d  = shadow_q;
      display_d = display_q;

      // Raw digit writes never collide with expansion, which only touches digits 0..7.
      shadow_d[FRAME_W-1 -: 8] = raw_we ? raw_seg : shadow_q[FRAME_W-1 -: 8];

      case (state_q)
         ST_IDLE: begin
            if (val_valid && val_ready_q) begin
               data_d    = val_data;
               dp_d      = val_dp;
               idx_d     = 3'd7;
               seen_nz_d = 1'b0;
               state_d   = ST_EXPAND;
            end else if (raw_we) begin
               state_d = ST_PENDING;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EXPAND: begin
            shadow_d[{idx_q, 3'b000} +: 8] = digit_s;
            seen_nz_d = seen_nz_q | (nib_s != 4'h0);
            if (idx_q == 3'd0) begin
               state_d = ST_PENDING;
            end else begin
               idx_d = idx_q - 3'd1;
            end
         end
         ST_PENDING: begin
            if (frame_tick) begin
               display_d = shadow_q ^ INV_MASK;
               // A raw byte arriving with the tick misses this commit and needs the next one.
               state_d   = raw_we ? ST_PENDING : ST_IDLE;
            end else begin
               state_d = ST_PENDING;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      val_ready_d = (state_d == ST_IDLE);
      pending_d   = (state_d != ST_IDLE);
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         val_ready_q <= 1'b0;
         pending_q   <= 1'b0;
         data_q      <= 32'h0000_0000;
         dp_q        <= 8'h00;
         idx_q       <= 3'd0;
         seen_nz_q   <= 1'b0;
         shadow_q    <= SHADOW_OFF;
         display_q   <= FRAME_OFF;
      end else begin
         state_q     <= state_d;
         val_ready_q <= val_ready_d;
         pending_q   <= pending_d;
         data_q      <= data_d;
         dp_q        <= dp_d;
         idx_q       <= idx_d;
         seen_nz_q   <= seen_nz_d;
         shadow_q    <= shadow_d;
         display_q   <= display_d;
      end
   end

   assign val_ready      = val_ready_q;
   assign commit_pending = pending_q;
   assign display_bits   = display_q;

endmodule

// File: tb/tb_display_frame_builder.sv
// Self-checking bench: three builder instances (default, no blanking, active-low)
// share one stimulus stream and are compared against a digit-level frame model.
module tb_display_frame_builder;

   localparam logic [7:0] DEC [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                       8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        val_valid = 1'b0;
   logic [31:0] val_data = 32'h0;
   logic [7:0]  val_dp = 8'h0;
   logic        raw_we = 1'b0;
   logic [7:0]  raw_seg = 8'h0;
   logic        frame_tick = 1'b0;

   logic [71:0] disp_a, disp_nb, disp_al;
   logic        rdy_a, rdy_nb, rdy_al;
   logic        cp_a, cp_nb, cp_al;

   wire [215:0] disp_all = {disp_a, disp_nb, disp_al};
   wire [2:0]   rdy_all  = {rdy_a, rdy_nb, rdy_al};
   wire [2:0]   cp_all   = {cp_a, cp_nb, cp_al};

   int n_checks = 0;
   int n_fail   = 0;

   // Model: pending shadow contents (m_*) and committed contents (c_*).
   logic [31:0] m_val, c_val;
   logic [7:0]  m_dp, c_dp, m_raw, c_raw;
   bit          m_have, c_have;

   always #5 clk = ~clk;

   display_frame_builder dut (
      .clk(clk), .rst_n(rst_n), .val_valid(val_valid), .val_ready(rdy_a),
      .val_data(val_data), .val_dp(val_dp), .raw_we(raw_we), .raw_seg(raw_seg),
      .frame_tick(frame_tick), .display_bits(disp_a), .commit_pending(cp_a));

   display_frame_builder #(.BLANK_LEADING(1'b0)) dut_nb (
      .clk(clk), .rst_n(rst_n), .val_valid(val_valid), .val_ready(rdy_nb),
      .val_data(val_data), .val_dp(val_dp), .raw_we(raw_we), .raw_seg(raw_seg),
      .frame_tick(frame_tick), .display_bits(disp_nb), .commit_pending(cp_nb));

   display_frame_builder #(.SEG_ACTIVE_LOW(1'b1)) dut_al (
      .clk(clk), .rst_n(rst_n), .val_valid(val_valid), .val_ready(rdy_al),
      .val_data(val_data), .val_dp(val_dp), .raw_we(raw_we), .raw_seg(raw_seg),
      .frame_tick(frame_tick), .display_bits(disp_al), .commit_pending(cp_al));

   // A digit is a leading zero when it and every higher nibble are zero.
   function automatic logic [71:0] model_frame(input logic [31:0] v, input logic [7:0] dp,
                                               input logic [7:0] raw, input bit blank, input bit have);
      logic [71:0] f;
      f = 72'h0;
      f[71:64] = raw;
      if (have) begin
         for (int d = 0; d < 8; d++) begin
            logic [31:0] upper;
            logic [7:0]  g;
            upper = v >> (4 * d);
            g = DEC[upper[3:0]];
            if (blank && d != 0 && upper == 32'h0) g = 8'h00;
            g[7] = dp[d];
            f[8*d +: 8] = g;
         end
      end
      return f;
   endfunction

   function automatic logic [215:0] exp_disp();
      logic [71:0] f1, f0;
      f1 = model_frame(c_val, c_dp, c_raw, 1'b1, c_have);
      f0 = model_frame(c_val, c_dp, c_raw, 1'b0, c_have);
      return {f1, f0, ~f1};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_commit();
      c_val = m_val; c_dp = m_dp; c_raw = m_raw; c_have = m_have;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0; val_valid = 1'b0; raw_we = 1'b0; frame_tick = 1'b0;
      step();
      step();
      m_have = 1'b0; m_raw = 8'h00; m_val = 32'h0; m_dp = 8'h0;
      model_commit();
   endtask

   // Offer a value (optionally with a raw byte) and return once the accept edge has passed.
   task automatic accept(input logic [31:0] v, input logic [7:0] dp, input bit with_raw, input logic [7:0] r);
      int n;
      n = 0;
      while (!rdy_a && n < 20) begin
         step();
         n++;
      end
      n_checks++;
      if (n >= 20) begin
         n_fail++;
         $display("FAIL accept_timeout: val_ready stayed %b, required 1", rdy_a);
      end
      val_valid = 1'b1; val_data = v; val_dp = dp; raw_we = with_raw; raw_seg = r;
      step();
      val_valid = 1'b0; raw_we = 1'b0;
      m_val = v; m_dp = dp; m_have = 1'b1;
      if (with_raw) m_raw = r;
   endtask

   task automatic expand_wait();
      repeat (8) step();
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      model_commit();
   endtask

   task automatic test_reset();
      apply_reset();
      n_checks++;
      if (rdy_all !== 3'b000) begin n_fail++; $display("FAIL reset_ready: got %b required 000", rdy_all); end
      n_checks++;
      if (cp_all !== 3'b000) begin n_fail++; $display("FAIL reset_pending: got %b required 000", cp_all); end
      n_checks++;
      if (disp_all !== {72'h0, 72'h0, {72{1'b1}}}) begin n_fail++; $display("FAIL reset_display: got %h", disp_all); end
      rst_n = 1'b1;
      step();
      n_checks++;
      if (rdy_all !== 3'b111) begin n_fail++; $display("FAIL reset_ready_rise: got %b required 111", rdy_all); end
   endtask

   task automatic test_basic();
      accept(32'h0000_0012, 8'h00, 1'b0, 8'h00);
      n_checks++;
      if (cp_all !== 3'b111 || rdy_all !== 3'b000) begin n_fail++; $display("FAIL basic_busy: cp %b ready %b required 111/000", cp_all, rdy_all); end
      expand_wait();
      n_checks++;
      if (disp_all !== exp_disp()) begin n_fail++; $display("FAIL basic_before_tick: got %h required %h", disp_all, exp_disp()); end
      tick();
      n_checks++;
      if (disp_a !== 72'h0000_0000_0000_00_065B) begin n_fail++; $display("FAIL basic_digits: got %h required %h", disp_a, 72'h065B); end
      n_checks++;
      if (disp_all !== exp_disp()) begin n_fail++; $display("FAIL basic_model: got %h required %h", disp_all, exp_disp()); end
      n_checks++;
      if (cp_all !== 3'b000) begin n_fail++; $display("FAIL basic_pending_clear: got %b required 000", cp_all); end
   endtask

   task automatic test_zero();
      accept(32'h0, 8'h00, 1'b0, 8'h00);
      expand_wait();
      tick();
      n_checks++;
      if (disp_a !== 72'h3F) begin n_fail++; $display("FAIL zero_blank: got %h required %h", disp_a, 72'h3F); end
      n_checks++;
      if (disp_nb !== {8'h00, {8{8'h3F}}}) begin n_fail++; $display("FAIL zero_noblank: got %h", disp_nb); end
   endtask

   task automatic test_deadbeef();
      accept(32'hDEAD_BEEF, 8'h01, 1'b1, 8'h80);
      expand_wait();
      tick();
      n_checks++;
      if (disp_a !== 72'h80_5E79_775E_7C79_79F1) begin n_fail++; $display("FAIL deadbeef: got %h required %h", disp_a, 72'h80_5E79_775E_7C79_79F1); end
      n_checks++;
      if (disp_all !== exp_disp()) begin n_fail++; $display("FAIL deadbeef_model: got %h required %h", disp_all, exp_disp()); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] va, vb;
      int bad;
      va = $urandom; vb = $urandom;
      val_valid = 1'b1; val_data = va; val_dp = 8'h00;
      step();
      m_val = va; m_dp = 8'h00; m_have = 1'b1;
      val_data = vb;
      bad = 0;
      for (int i = 0; i < 11; i++) begin
         if (rdy_all !== 3'b000) bad++;
         step();
      end
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL bp_ready_low: ready high in %0d busy cycles, required 0", bad); end
      tick();
      n_checks++;
      if (disp_all !== exp_disp()) begin n_fail++; $display("FAIL bp_first_value: got %h required %h", disp_all, exp_disp()); end
      n_checks++;
      if (rdy_all !== 3'b111 || cp_all !== 3'b000) begin n_fail++; $display("FAIL bp_idle: ready %b cp %b required 111/000", rdy_all, cp_all); end
      step();
      val_valid = 1'b0;
      m_val = vb;
      n_checks++;
      if (cp_all !== 3'b111) begin n_fail++; $display("FAIL bp_second_accept: cp %b required 111", cp_all); end
      expand_wait();
      tick();
      n_checks++;
      if (disp_all !== exp_disp()) begin n_fail++; $display("FAIL bp_second_value: got %h required %h", disp_all, exp_disp()); end
   endtask

   task automatic test_tick_in_expand();
      accept(32'h0000_0001, 8'h00, 1'b0, 8'h00);
      repeat (3) step();
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
      n_checks++;
      if (disp_all !== exp_disp() || cp_all !== 3'b111) begin n_fail++; $display("FAIL tick_expand: got %h cp %b", disp_all, cp_all); end
      repeat (3) step();
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
      n_checks++;
      if (disp_all !== exp_disp() || cp_all !== 3'b111) begin n_fail++; $display("FAIL tick_enter_pending: got %h cp %b", disp_all, cp_all); end
      tick();
      n_checks++;
      if (disp_all !== exp_disp()) begin n_fail++; $display("FAIL tick_commit: got %h required %h", disp_all, exp_disp()); end
   endtask

   task automatic test_raw_at_commit();
      logic [7:0] r;
      r = 8'($urandom) | 8'h01;
      if (r == m_raw) r = ~r;
      accept($urandom, 8'($urandom), 1'b0, 8'h00);
      expand_wait();
      frame_tick = 1'b1; raw_we = 1'b1; raw_seg = r;
      step();
      frame_tick = 1'b0; raw_we = 1'b0;
      model_commit();
      m_raw = r;
      n_checks++;
      if (disp_all !== exp_disp()) begin n_fail++; $display("FAIL raw_commit_old: got %h required %h", disp_all, exp_disp()); end
      n_checks++;
      if (cp_all !== 3'b111) begin n_fail++; $display("FAIL raw_commit_pending: got %b required 111", cp_all); end
      tick();
      n_checks++;
      if (disp_all !== exp_disp() || cp_all !== 3'b000) begin n_fail++; $display("FAIL raw_commit_new: got %h cp %b required %h", disp_all, cp_all, exp_disp()); end
   endtask

   task automatic test_reset_pending();
      accept(32'h0000_0001, 8'h00, 1'b0, 8'h00);
      expand_wait();
      apply_reset();
      rst_n = 1'b1;
      step();
      tick();
      n_checks++;
      if (disp_all !== {72'h0, 72'h0, {72{1'b1}}} || cp_all !== 3'b000) begin n_fail++; $display("FAIL reset_pending: got %h cp %b", disp_all, cp_all); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            raw_we = 1'b1; raw_seg = 8'($urandom);
            step();
            raw_we = 1'b0;
            m_raw = raw_seg;
            n_checks++;
            if (cp_all !== 3'b111) begin n_fail++; $display("FAIL rand_raw_pending: iter %0d cp %b required 111", i, cp_all); end
         end else begin
            accept($urandom >> $urandom_range(0, 31), 8'($urandom), 1'($urandom), 8'($urandom));
            expand_wait();
         end
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) step();
         tick();
         n_checks++;
         if (disp_all !== exp_disp()) begin n_fail++; $display("FAIL rand_frame: iter %0d got %h required %h", i, disp_all, exp_disp()); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero();
      test_deadbeef();
      test_back_to_back();
      test_tick_in_expand();
      test_raw_at_commit();
      test_random();
      test_reset_pending();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/display_frame_builder.md
# display_frame_builder

Upstream feeder for the 72-bit serial display shifter: it turns a 32-bit hex value plus decimal points, and one raw status digit, into the nine-digit, 8-bits-per-digit segment pattern that the shifter clocks out. Internally it holds a shadow frame built over several cycles. It commits that frame to `display_bits` only on the shifter's frame boundary, so a half-updated value is never shifted out. It sits between the CPU/debug register interface and the display shifter, in the same clock domain.

## Interface
Parameters:
- `SEG_ACTIVE_LOW`, default 0: 1 inverts every segment and dp bit on `display_bits`; "off" becomes 1.
- `BLANK_LEADING`, default 1: 1 blanks leading zero hex digits 7..1. Digit 0 is never blanked.

Ports:
- `clk`  in  1  system clock; one clock, all logic on rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `val_valid`  in  1  new hex value offered.
- `val_ready`  out  1  block can accept a value.
- `val_data`  in  32  hex value; nibble i drives digit i.
- `val_dp`  in  8  dp enable per digit 0..7.
- `raw_we`  in  1  write `raw_seg` to digit 8 of the shadow frame.
- `raw_seg`  in  8  raw segment byte for digit 8, with dp in bit 7.
- `frame_tick`  in  1  one-cycle pulse at the shifter's frame boundary; driven by its `timerOverflow`.
- `display_bits`  out  72  committed frame; digit d occupies bits [8d+7:8d], bit order a,b,c,d,e,f,g,dp (LSB first).
- `commit_pending`  out  1  shadow frame differs from committed frame and is waiting for `frame_tick`.

## Operation
- States: IDLE, EXPAND, PENDING.
- IDLE
  - `val_ready`=1.
  - `val_valid & val_ready` latches data/dp, sets idx=7, clears `seen_nz`, and goes to EXPAND.
  - `raw_we` alone goes to PENDING.
- EXPAND
  - One digit per cycle, idx 7 down to 0.
  - shadow[idx] = decode(nibble) | dp<<7.
  - If `BLANK_LEADING` and nibble==0 and !`seen_nz` and idx!=0, segments a–g=0 while dp is kept.
  - A nonzero nibble sets `seen_nz`.
  - After idx 0, go to PENDING.
- PENDING: on `frame_tick`, `display_bits` <= shadow (all 72 bits, inversion applied) and go to IDLE.
- Decode: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- `raw_we` writes shadow[8] in any state. It is never decoded or blanked.
- `commit_pending` = (state != IDLE).

## Timing
- Reset (while `rst_n`=0 at an edge):
  - state=IDLE, `val_ready`=0 (registered).
  - shadow all off; `display_bits` all off (0, or all 1s if `SEG_ACTIVE_LOW`); `commit_pending`=0.
  - `val_ready` rises on the first edge after reset release.
- `val_ready` is registered and equals 1 exactly when state is IDLE.
- Accept at edge T: EXPAND occupies T+1..T+8, PENDING from T+9.
- Commit: `display_bits` changes on the edge that samples `frame_tick`=1 while in PENDING; IDLE holds from the following cycle.
- `frame_tick` outside PENDING is ignored, including the cycle the block enters PENDING.
- `raw_we` in the same cycle as a value accept: both take effect; state goes to EXPAND.
- `raw_we` in the same cycle as commit: the new byte lands in shadow but not in this commit; state stays PENDING.
- Reset mid-EXPAND/PENDING: the frame is discarded and the display goes off.
- `display_bits` is stable for whole frames, and changes only at a frame boundary.

## Structure
- Package `display_pkg`:
  - state encoding (2 bits);
  - segment bit positions;
  - `SEG_OFF` constant;
  - digit count 9 and frame width 72.
- Sub-module `hex_to_7seg`: combinational 4-bit to 7-bit decoder, instantiated once and muxed by idx.

## Test plan
- Reset, then value 0x00000012, dp=0, then `frame_tick`: `display_bits`[7:0]=5B, [15:8]=06, [71:16]=0, `commit_pending` 1→0.
- Value 0x00000000 with `BLANK_LEADING`=1: only digit 0 = 3F. Same with `BLANK_LEADING`=0: digits 0..7 = 3F.
- Value 0xDEADBEEF, dp=0x01, `raw_we` raw_seg=0x80: digits 7..0 = 5E,79,77,5E,7C,79,79,F1 and digit 8 = 80.
- Backpressure: `val_valid` held during EXPAND/PENDING → `val_ready`=0, no second accept, and the held value is accepted on the first IDLE cycle.
- `frame_tick` pulsed during EXPAND: `display_bits` unchanged. Next tick in PENDING commits.
- `SEG_ACTIVE_LOW`=1: `display_bits`=all 1s after reset, and digit value 1 appears as F9. Reset asserted while in PENDING: `display_bits` returns to all off and the value is never committed.
